mem_responder: RTL and testbench

Memory-side responder for the CPU's MAR/MDR memory port. It accepts level-held read/write requests from the datapath and sequences a synchronous single-port RAM with a configurable latency. It returns read data toward the MDR with a one-cycle `mem_ready` pulse, and flags out-of-range or malformed requests. It sits between the datapath's MAR/MDR/read/write signals and the RAM macro, so the control unit can stall on memory instead of assuming fixed timing.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU-side memory port bundle: MAR/MDR request lines from the datapath and
// the completion/error/read-data lines back toward the MDR input mux.
interface mem_responder_if #(
  parameter int REG_SIZE = 32
);
  logic [REG_SIZE-1:0] mar_data;
  logic [REG_SIZE-1:0] mdr_data;
  logic                rd_req;
  logic                wr_req;
  logic                mem_ready;
  logic                mem_err;
  logic [REG_SIZE-1:0] m_data_in;

  // Datapath / control-unit side
  modport master (
    output mar_data, mdr_data, rd_req, wr_req,
    input  mem_ready, mem_err, m_data_in
  );

  // Memory responder side
  modport slave (
    input  mar_data, mdr_data, rd_req, wr_req,
    output mem_ready, mem_err, m_data_in
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts level-held read/write requests, sequences a
// synchronous single-port RAM with configurable wait states and read latency,
// and answers with a one-cycle mem_ready pulse plus an error flag.
module mem_responder #(
  parameter int REG_SIZE     = 32,
  parameter int ADDR_BITS    = 9,
  parameter int READ_LATENCY = 2,
  parameter int WAIT_STATES  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_responder_if.slave       bus,
  output logic [ADDR_BITS-1:0] ram_address,
  output logic [REG_SIZE-1:0]  ram_data,
  output logic                 ram_wren,
  input  logic [REG_SIZE-1:0]  ram_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP,
    S_HOLD
  } state_t;

  // Down-counter preloads: the counter reaching zero marks the last cycle
  // of the current state, so preload with (cycles - 1).
  localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [2:0] READ_INIT = 3'(READ_LATENCY - 1);

  state_t               state_reg, state_next;
  logic [2:0]           cnt_reg, cnt_next;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [REG_SIZE-1:0]  data_reg;
  logic                 op_rd_reg;
  logic                 op_wr_reg;
  logic                 err_reg;
  logic [REG_SIZE-1:0]  m_data_reg;

  logic                 accept;
  logic                 capture;
  logic                 req_any;
  logic                 req_err;

  // Request decode at the accepting edge: out-of-range upper address bits or
  // simultaneous read+write are both reported as errors.
  assign req_any = bus.rd_req | bus.wr_req;
  assign req_err = (|bus.mar_data[REG_SIZE-1:ADDR_BITS]) | (bus.rd_req & bus.wr_req);

  // Next-state and counter sequencing
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_any) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next = S_WAIT;
            cnt_next   = WAIT_INIT;
          end else begin
            state_next = S_ACCESS;
            cnt_next   = (bus.rd_req && !req_err) ? READ_INIT : 3'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_ACCESS;
          cnt_next   = (op_rd_reg && !err_reg) ? READ_INIT : 3'd0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_ACCESS: begin
        if (cnt_reg == 3'd0) begin
          state_next = S_RESP;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_RESP: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        // Only a fully released request re-arms the responder, so a request
        // still held after completion is never executed twice.
        if (!req_any) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // State, counter, request latches and read-data capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 3'd0;
      addr_reg   <= '0;
      data_reg   <= '0;
      op_rd_reg  <= 1'b0;
      op_wr_reg  <= 1'b0;
      err_reg    <= 1'b0;
      m_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= bus.mar_data[ADDR_BITS-1:0];
        data_reg  <= bus.mdr_data;
        op_rd_reg <= bus.rd_req;
        op_wr_reg <= bus.wr_req;
        err_reg   <= req_err;
      end
      if (capture) begin
        if (err_reg) begin
          m_data_reg <= '0;
        end else if (op_rd_reg) begin
          m_data_reg <= ram_q;
        end
      end
    end
  end

  // Outputs come only from registers or state decode; the async reset of
  // state_reg clears mem_ready/mem_err/ram_wren without waiting for a clock.
  assign ram_address   = addr_reg;
  assign ram_data      = data_reg;
  assign ram_wren      = (state_reg == S_ACCESS) && op_wr_reg && !err_reg;
  assign bus.mem_ready = (state_reg == S_RESP);
  assign bus.mem_err   = (state_reg == S_RESP) && err_reg;
  assign bus.m_data_in = m_data_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: unit 0 uses default parameters, unit 1 adds three
// wait states. Each unit talks to a small RAM model with a registered address.
// Expected responses are queued at issue time and checked by a monitor on
// every mem_ready pulse.
module tb_mem_responder;

  logic clk;
  logic reset_n;

  logic [1:0]  rd_drv;
  logic [1:0]  wr_drv;
  logic [31:0] mar_drv [2];
  logic [31:0] mdr_drv [2];

  logic [1:0]  ready_o;
  logic [1:0]  err_o;
  logic [1:0]  wren_o;
  logic [31:0] mdi_o [2];
  logic [8:0]  addr_o [2];
  logic [31:0] ram_data_o [2];
  logic [31:0] ram_q_i [2];

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t  sb_q0 [$];
  exp_t  sb_q1 [$];
  string nm_q0 [$];
  string nm_q1 [$];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      mem_responder_if #(.REG_SIZE(32)) bus ();
      logic [31:0] mem [512];
      logic [8:0]  addr_q;

      assign bus.rd_req   = rd_drv[gi];
      assign bus.wr_req   = wr_drv[gi];
      assign bus.mar_data = mar_drv[gi];
      assign bus.mdr_data = mdr_drv[gi];
      assign ready_o[gi]  = bus.mem_ready;
      assign err_o[gi]    = bus.mem_err;
      assign mdi_o[gi]    = bus.m_data_in;

      mem_responder #(
        .REG_SIZE(32),
        .ADDR_BITS(9),
        .READ_LATENCY(2),
        .WAIT_STATES((gi == 1) ? 3 : 0)
      ) u_dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .ram_address(addr_o[gi]),
        .ram_data(ram_data_o[gi]),
        .ram_wren(wren_o[gi]),
        .ram_q(ram_q_i[gi])
      );

      // RAM model: registered address, array read behind it
      always @(posedge clk) begin
        if (wren_o[gi]) mem[addr_o[gi]] <= ram_data_o[gi];
        addr_q <= addr_o[gi];
      end
      assign ram_q_i[gi] = mem[addr_q];
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every mem_ready pulse must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t  e;
    string nm;
    if (ready_o[0]) begin
      if (sb_q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready_u0: got mem_ready=1 expected 0");
      end else begin
        e  = sb_q0.pop_front();
        nm = nm_q0.pop_front();
        chk({nm, "_err"}, {31'd0, err_o[0]}, {31'd0, e.err});
        chk({nm, "_data"}, mdi_o[0], e.data);
        $display("u0 %s: err=%0d data=%h", nm, err_o[0], mdi_o[0]);
      end
    end
    if (ready_o[1]) begin
      if (sb_q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready_u1: got mem_ready=1 expected 0");
      end else begin
        e  = sb_q1.pop_front();
        nm = nm_q1.pop_front();
        chk({nm, "_err"}, {31'd0, err_o[1]}, {31'd0, e.err});
        chk({nm, "_data"}, mdi_o[1], e.data);
        $display("u1 %s: err=%0d data=%h", nm, err_o[1], mdi_o[1]);
      end
    end
  end

  // Issue one request on unit u, measure edges from accept to mem_ready,
  // count write-enable cycles, check address stability, then release.
  task automatic do_req(input int u, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_wren, input int hold,
                        input string name);
    exp_t e;
    int   n;
    int   wren_cnt;
    int   addr_bad;
    int   extra;
    @(negedge clk);
    rd_drv[u]  = rd;
    wr_drv[u]  = wr;
    mar_drv[u] = addr;
    mdr_drv[u] = wdata;
    e.err  = exp_err;
    e.data = exp_data;
    if (u == 0) begin
      sb_q0.push_back(e);
      nm_q0.push_back(name);
    end else begin
      sb_q1.push_back(e);
      nm_q1.push_back(name);
    end
    n = 0;
    wren_cnt = 0;
    addr_bad = 0;
    forever begin
      @(negedge clk);
      // scramble the request lines after acceptance; they must be ignored
      if (n == 0) begin
        mar_drv[u] = ~addr;
        mdr_drv[u] = ~wdata;
      end
      if (addr_o[u] != addr[8:0]) addr_bad++;
      if (wren_o[u]) wren_cnt++;
      if (ready_o[u]) break;
      n++;
      if (n > 40) break;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_wren_cycles"}, wren_cnt, exp_wren);
    chk({name, "_addr_stable"}, addr_bad, 0);
    extra = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ready_o[u]) extra++;
    end
    if (hold > 0) chk({name, "_hold_pulses"}, extra, 0);
    rd_drv[u] = 1'b0;
    wr_drv[u] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    rd_drv     = 2'b00;
    wr_drv     = 2'b00;
    mar_drv[0] = '0;
    mar_drv[1] = '0;
    mdr_drv[0] = '0;
    mdr_drv[1] = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {30'd0, ready_o}, 32'd0);
    chk("reset_wren", {30'd0, wren_o}, 32'd0);
    chk("reset_err", {30'd0, err_o}, 32'd0);
    chk("reset_mdata", mdi_o[0], 32'd0);
    chk("reset_addr", {23'd0, addr_o[0]}, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // preload through the responder itself (writes leave m_data_in alone)
    do_req(0, 0, 1, 32'h0000_0000, 32'h1234_5678, 0, 32'h0, 1, 1, 0, "pre_w0");
    do_req(0, 0, 1, 32'h0000_0007, 32'h0000_0777, 0, 32'h0, 1, 1, 0, "pre_w7");
    do_req(0, 0, 1, 32'h0000_01FF, 32'hA5A5_A5A5, 0, 32'h0, 1, 1, 0, "pre_w1ff");

    do_req(0, 0, 1, 32'h0000_0005, 32'hDEAD_BEEF, 0, 32'h0,         1, 1, 0, "write5");
    do_req(0, 1, 0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 2, 0, 0, "read5");
    do_req(0, 0, 1, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0,         1, 0, 0, "write_oor");
    do_req(0, 1, 0, 32'h0000_0000, 32'h0,         0, 32'h1234_5678, 2, 0, 0, "read0_after_oor");
    do_req(0, 1, 0, 32'h0000_0200, 32'h0,         1, 32'h0,         1, 0, 0, "read_oor");
    do_req(0, 1, 0, 32'h0000_01FF, 32'h0,         0, 32'hA5A5_A5A5, 2, 0, 0, "read_top");
    do_req(0, 1, 1, 32'h0000_0007, 32'hFFFF_FFFF, 1, 32'h0,         1, 0, 0, "rd_wr_both");
    do_req(0, 1, 0, 32'h0000_0007, 32'h0,         0, 32'h0000_0777, 2, 0, 0, "read7_after_both");
    do_req(0, 1, 0, 32'h8000_0005, 32'h0,         1, 32'h0,         1, 0, 0, "read_msb_oor");
    do_req(0, 1, 0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 2, 0, 10, "read5_held");
    do_req(0, 1, 0, 32'h0000_0005, 32'h0,         0, 32'hDEAD_BEEF, 2, 0, 0, "read5_again");

    // wait-state unit: write costs 3+1 edges, read 3+2 edges
    do_req(1, 0, 1, 32'h0000_0003, 32'h3333_4444, 0, 32'h0,         4, 1, 0, "ws_write3");
    do_req(1, 1, 0, 32'h0000_0003, 32'h0,         0, 32'h3333_4444, 5, 0, 0, "ws_read3");

    // reset in the middle of a read's ACCESS phase
    @(negedge clk);
    mar_drv[0] = 32'h0000_0005;
    rd_drv[0]  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midread_addr", {23'd0, addr_o[0]}, 32'd5);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready_o[0]}, 32'd0);
    chk("rst_wren", {31'd0, wren_o[0]}, 32'd0);
    chk("rst_err", {31'd0, err_o[0]}, 32'd0);
    chk("rst_mdata", mdi_o[0], 32'd0);
    chk("rst_addr", {23'd0, addr_o[0]}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_ready", {31'd0, ready_o[0]}, 32'd0);
    mar_drv[0] = 32'h0000_0007;
    @(posedge clk);
    #3 reset_n = 1'b1;
    do_req(0, 1, 0, 32'h0000_0007, 32'h0, 0, 32'h0000_0777, 2, 0, 0, "post_reset_read");

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q0.size() + sb_q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
